// File: rtl/half_adder_pipe.sv
// WIDTH-lane half adder with one registered stage, a valid flag, a carry summary and a carry count.
// Define HALF_ADDER_PIPE_STATS_EN to add the saturating o_carry_events counter.
module half_adder_pipe #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_bit1,
  input  logic [WIDTH-1:0] i_bit2,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_carry,
  output logic             o_carry_any,
  output logic [CNT_W-1:0] o_carry_cnt
`ifdef HALF_ADDER_PIPE_STATS_EN
  ,
  output logic [15:0]      o_carry_events
`endif
);

  // Valid semantics: i_valid qualifies i_bit1/i_bit2 on the same rising edge, with
  // no backpressure, so every valid cycle is accepted. o_valid marks the cycle in
  // which the registered results belong to an operand pair that was just accepted.
  // Operand bits are ignored while i_valid is low.

  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] carry_next;
  logic [CNT_W-1:0] cnt_next;

  assign sum_next   = i_bit1 ^ i_bit2;
  assign carry_next = i_bit1 & i_bit2;

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next = cnt_next + CNT_W'(carry_next[i]);
    end
  end

  // Data registers only load on valid cycles, so they hold across idle gaps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_sum       <= '0;
      o_carry     <= '0;
      o_carry_any <= 1'b0;
      o_carry_cnt <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_sum       <= sum_next;
        o_carry     <= carry_next;
        o_carry_any <= |carry_next;
        o_carry_cnt <= cnt_next;
      end
    end
  end

`ifdef HALF_ADDER_PIPE_STATS_EN
  // Counts accepted operand pairs that produced at least one carry; sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_carry_events <= '0;
    end else if (i_valid && (|carry_next) && (o_carry_events != 16'hFFFF)) begin
      o_carry_events <= o_carry_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_half_adder_pipe.sv
// Directed bench for half_adder_pipe at WIDTH=8: reset, truth table, vectors, hold, mid-stream reset.
// Stats checks compile in when HALF_ADDER_PIPE_STATS_EN is defined.
module tb_half_adder_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 7;

  logic             clk;
  logic             rst_n;
  logic             i_valid;
  logic [WIDTH-1:0] i_bit1;
  logic [WIDTH-1:0] i_bit2;
  logic             o_valid;
  logic [WIDTH-1:0] o_sum;
  logic [WIDTH-1:0] o_carry;
  logic             o_carry_any;
  logic [CNT_W-1:0] o_carry_cnt;
`ifdef HALF_ADDER_PIPE_STATS_EN
  logic [15:0]      o_carry_events;
`endif

  int tests_run;
  int tests_failed;

  half_adder_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .i_bit1      (i_bit1),
    .i_bit2      (i_bit2),
    .o_valid     (o_valid),
    .o_sum       (o_sum),
    .o_carry     (o_carry),
    .o_carry_any (o_carry_any),
    .o_carry_cnt (o_carry_cnt)
`ifdef HALF_ADDER_PIPE_STATS_EN
    ,
    .o_carry_events (o_carry_events)
`endif
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present operands at the falling edge, return 1 time unit after the next rising edge.
  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    i_valid = v;
    i_bit1  = a;
    i_bit2  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] s,
                           input logic [WIDTH-1:0] c, input logic any, input logic [CNT_W-1:0] cnt);
    check({tag, ".valid"}, 64'(o_valid), 64'(v));
    check({tag, ".sum"},   64'(o_sum), 64'(s));
    check({tag, ".carry"}, 64'(o_carry), 64'(c));
    check({tag, ".any"},   64'(o_carry_any), 64'(any));
    check({tag, ".cnt"},   64'(o_carry_cnt), 64'(cnt));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_bit1  = '0;
    i_bit2  = '0;

    // Reset held with random stimulus and clock running
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    check_out("reset_hold", 1'b0, 8'h00, 8'h00, 1'b0, 7'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Truth table on lane 0, back-to-back valid cycles
    drive(1'b1, 8'h00, 8'h00);
    check_out("tt00", 1'b1, 8'h00, 8'h00, 1'b0, 7'd0);
    drive(1'b1, 8'h00, 8'h01);
    check_out("tt01", 1'b1, 8'h01, 8'h00, 1'b0, 7'd0);
    drive(1'b1, 8'h01, 8'h00);
    check_out("tt10", 1'b1, 8'h01, 8'h00, 1'b0, 7'd0);
    drive(1'b1, 8'h01, 8'h01);
    check_out("tt11", 1'b1, 8'h00, 8'h01, 1'b1, 7'd1);

    // Vectors
    drive(1'b1, 8'hF0, 8'hCC);
    check_out("vec_f0_cc", 1'b1, 8'h3C, 8'hC0, 1'b1, 7'd2);
    drive(1'b1, 8'hFF, 8'hFF);
    check_out("vec_ff_ff", 1'b1, 8'h00, 8'hFF, 1'b1, 7'd8);
    drive(1'b1, 8'hA5, 8'h5A);
    check_out("vec_a5_5a", 1'b1, 8'hFF, 8'h00, 1'b0, 7'd0);
    drive(1'b1, 8'h0F, 8'hFF);
    check_out("vec_0f_ff", 1'b1, 8'hF0, 8'h0F, 1'b1, 7'd4);

    // Hold across idle cycles, including unknown operands
    drive(1'b1, 8'hF0, 8'hCC);
    check_out("hold_load", 1'b1, 8'h3C, 8'hC0, 1'b1, 7'd2);
    drive(1'b0, 8'hFF, 8'h00);
    check_out("hold_idle", 1'b0, 8'h3C, 8'hC0, 1'b1, 7'd2);
    drive(1'b0, 'x, 'x);
    check_out("hold_x", 1'b0, 8'h3C, 8'hC0, 1'b1, 7'd2);

    // Asynchronous reset between edges during valid traffic
    drive(1'b1, 8'hFF, 8'hFF);
    check_out("pre_rst", 1'b1, 8'h00, 8'hFF, 1'b1, 7'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 8'h00, 8'h00, 1'b0, 7'd0);
    @(negedge clk);
    i_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_rst_idle", 1'b0, 8'h00, 8'h00, 1'b0, 7'd0);
    drive(1'b1, 8'h33, 8'h11);
    check_out("post_rst_first", 1'b1, 8'h22, 8'h11, 1'b1, 7'd2);

`ifdef HALF_ADDER_PIPE_STATS_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("events_reset", 64'(o_carry_events), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h81, 8'h01);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hAA, 8'h55);
    for (int i = 0; i < 2; i++) drive(1'b0, 8'hFF, 8'hFF);
    check("events_5", 64'(o_carry_events), 64'd5);
    for (int i = 0; i < 65530; i++) drive(1'b1, 8'h01, 8'h01);
    check("events_max", 64'(o_carry_events), 64'hFFFF);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h01, 8'h01);
    check("events_sat", 64'(o_carry_events), 64'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
